fetch_queue_ctrl: RTL and testbench

- Instruction fetch controller for the tomas core. It sequences an addressed, 1-cycle-latency 16-bit instruction ROM (256 words) and buffers fetched words in a small queue.
- It presents instructions with their fetch address to the issue stage over a valid/ready handshake.
- It supports redirect (flush and refetch from a new address) and stops fetching after a HALT opcode.

---
 rtl/tomas_pkg.sv | 23 ++
 rtl/fetch_queue_ctrl_if.sv | 25 ++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_queue_ctrl.sv | 86 ++++++++
 tb/tb_fetch_queue_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/tomas_pkg.sv
// Shared types and constants for the tomas fetch path.
// Field layout of instruction words and fetch-queue entries.
package tomas_pkg;

   localparam int INSTR_W = 16;
   localparam int ADDR_W  = 8;
   localparam int OP_HI   = 15;
   localparam int OP_LO   = 12;

   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fq_entry_t;

   function automatic logic [3:0] opcode(
      input logic [INSTR_W-1:0] i
   );
      return i[OP_HI:OP_LO];
   endfunction

endpackage

// File: rtl/fetch_queue_ctrl_if.sv
// Issue-side valid/ready bundle between fetch queue and issue stage.
// The fetch queue is the master; the issue stage is the slave.
interface fetch_queue_ctrl_if;
   import tomas_pkg::*;

   logic               valid;
   logic               ready;
   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  pc;

   modport master (
      output valid,
      output instr,
      output pc,
      input  ready
   );

   modport slave (
      input  valid,
      input  instr,
      input  pc,
      output ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {instr,pc} entries with flush.
// Head is shown combinationally and reads as zero when empty.
module fetch_fifo
   import tomas_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic      clock,
   input  logic      resetn,
   input  logic      flush,
   input  logic      push,
   input  logic      pop,
   input  fq_entry_t wdata,
   output fq_entry_t rdata,
   output logic [PW:0] count
);

   fq_entry_t     mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   always_ff @(posedge clock) begin
      if (push && !flush)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (!push && pop)
            count <= count - 1'b1;
      end
   end

   assign rdata = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Instruction fetch controller: sequences a 1-cycle ROM, buffers
// fetched words, handles redirect and stops after a HALT word.
module fetch_queue_ctrl
   import tomas_pkg::*;
#(
   parameter  int               DEPTH      = 4,
   parameter  logic [ADDR_W-1:0] START_ADDR = 8'd0,
   parameter  logic [3:0]       HALT_OP    = OP_HALT,
   localparam int               CW         = $clog2(DEPTH) + 1
) (
   input  logic               clock,
   input  logic               resetn,
   output logic               rom_read,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [INSTR_W-1:0] rom_data,
   fetch_queue_ctrl_if.master issue,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic               halted,
   output logic [CW-1:0]      occupancy
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic              drop_next;
   logic              push;
   logic              pop;
   logic              halt_hit;
   logic [CW:0]       used;
   fq_entry_t         wr_entry;
   fq_entry_t         head;

   // Credit counts the outstanding read so a push can never overflow.
   assign used = {1'b0, occupancy} + {{CW{1'b0}}, inflight};

   assign rom_read = resetn && !halted && !redirect_valid
                  && !drop_next && (used < (CW+1)'(DEPTH));
   assign rom_addr = pc;

   assign push     = inflight && !drop_next && !redirect_valid;
   assign halt_hit = push && (opcode(rom_data) == HALT_OP);
   assign wr_entry = {rom_data, inflight_pc};

   assign issue.valid = (occupancy != '0) && !redirect_valid;
   assign pop         = issue.valid && issue.ready;
   assign issue.instr = head.instr;
   assign issue.pc    = head.pc;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .flush  (redirect_valid),
      .push   (push),
      .pop    (pop),
      .wdata  (wr_entry),
      .rdata  (head),
      .count  (occupancy)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pc          <= START_ADDR;
         inflight_pc <= '0;
         inflight    <= 1'b0;
         drop_next   <= 1'b0;
         halted      <= 1'b0;
      end else if (redirect_valid) begin
         pc        <= redirect_addr;
         inflight  <= 1'b0;
         drop_next <= 1'b0;
         halted    <= 1'b0;
      end else begin
         inflight  <= rom_read;
         // The read racing the HALT word is discarded on return.
         drop_next <= halt_hit && rom_read;
         if (rom_read) begin
            pc          <= pc + 1'b1;
            inflight_pc <= pc;
         end
         if (halt_hit)
            halted <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Scoreboard bench for fetch_queue_ctrl with a behavioural ROM.
// Stimulus queues expected {instr,pc}; a monitor checks each issue.
module tb_fetch_queue_ctrl;
   import tomas_pkg::*;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        rom_read;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data = '0;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_addr = '0;
   logic        halted;
   logic [2:0]  occupancy;

   logic [15:0] rom [256];
   fq_entry_t   exp_q [$];
   fq_entry_t   e;
   int          checks = 0;
   int          errors = 0;

   fetch_queue_ctrl_if issue_if ();

   fetch_queue_ctrl #(
      .DEPTH      (4),
      .START_ADDR (8'd0),
      .HALT_OP    (4'b1111)
   ) dut (
      .clock          (clock),
      .resetn         (resetn),
      .rom_read       (rom_read),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .issue          (issue_if),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halted         (halted),
      .occupancy      (occupancy)
   );

   always #5 clock = ~clock;

   always @(posedge clock)
      rom_data <= rom_read ? rom[rom_addr] : 16'hEEEE;

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h",
                  name, act, req);
      end
   endtask

   task automatic step(int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic expect_word(logic [15:0] i, logic [7:0] a);
      exp_q.push_back({i, a});
   endtask

   task automatic drain(string name);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++)
         step(1);
      chk(name, exp_q.size(), 0);
   endtask

   task automatic redirect(logic [7:0] a);
      redirect_addr  = a;
      redirect_valid = 1'b1;
      #1;
      chk("redir_valid", issue_if.valid, 0);
      chk("redir_read", rom_read, 0);
      step(1);
      redirect_valid = 1'b0;
      #1;
   endtask

   always @(negedge clock) begin
      if (issue_if.valid && issue_if.ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: got pc %0h instr %0h, required none",
                     issue_if.pc, issue_if.instr);
         end else begin
            e = exp_q.pop_front();
            chk("issue_instr", issue_if.instr, e.instr);
            chk("issue_pc", issue_if.pc, e.pc);
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++)
         rom[i] = 16'h1000 + 16'(i);
      rom[4]     = 16'hF004;
      rom[8'h83] = 16'hF083;
      issue_if.ready = 1'b1;

      // reset state
      step(2);
      chk("rst_read", rom_read, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_valid", issue_if.valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_instr", issue_if.instr, 0);
      chk("rst_pc", issue_if.pc, 0);

      // streaming from reset, HALT at word 4
      expect_word(16'h1000, 8'h00);
      expect_word(16'h1001, 8'h01);
      expect_word(16'h1002, 8'h02);
      expect_word(16'h1003, 8'h03);
      expect_word(16'hF004, 8'h04);
      resetn = 1'b1;
      #1;
      chk("c0_read", rom_read, 1);
      chk("c0_addr", rom_addr, 0);
      step(1);
      chk("c1_addr", rom_addr, 1);
      chk("c1_valid", issue_if.valid, 0);
      step(1);
      chk("c2_valid", issue_if.valid, 1);
      chk("c2_pc", issue_if.pc, 0);
      step(4);
      chk("t1_halted", halted, 1);
      chk("t1_read", rom_read, 0);
      drain("t1_drain");
      step(3);
      chk("t1_occ", occupancy, 0);

      // backpressure
      issue_if.ready = 1'b0;
      expect_word(16'h1000, 8'h00);
      expect_word(16'h1001, 8'h01);
      expect_word(16'h1002, 8'h02);
      expect_word(16'h1003, 8'h03);
      expect_word(16'hF004, 8'h04);
      redirect(8'h00);
      chk("bp_read0", rom_read, 1);
      chk("bp_addr0", rom_addr, 0);
      chk("bp_halted", halted, 0);
      step(4);
      chk("bp_credit_read", rom_read, 0);
      chk("bp_occ3", occupancy, 3);
      step(1);
      chk("bp_occ4", occupancy, 4);
      step(2);
      chk("bp_occ_hold", occupancy, 4);
      chk("bp_read_hold", rom_read, 0);
      issue_if.ready = 1'b1;
      step(1);
      chk("bp_resume_read", rom_read, 1);
      chk("bp_resume_addr", rom_addr, 4);
      drain("bp_drain");

      // HALT at word 2
      rom[2] = 16'hF000;
      expect_word(16'h1000, 8'h00);
      expect_word(16'h1001, 8'h01);
      expect_word(16'hF000, 8'h02);
      redirect(8'h00);
      step(3);
      chk("h_pre_halted", halted, 0);
      chk("h_read3", rom_read, 1);
      chk("h_addr3", rom_addr, 3);
      step(1);
      chk("h_halted", halted, 1);
      chk("h_read_off", rom_read, 0);
      drain("h_drain");
      step(3);
      chk("h_occ", occupancy, 0);
      chk("h_read_stay", rom_read, 0);
      rom[2] = 16'h1002;

      // redirect with 3 queued and a read in flight
      issue_if.ready = 1'b0;
      redirect(8'h00);
      chk("r_halt_clear", halted, 0);
      step(4);
      chk("r_occ3", occupancy, 3);
      issue_if.ready = 1'b1;
      expect_word(16'h1080, 8'h80);
      expect_word(16'h1081, 8'h81);
      expect_word(16'h1082, 8'h82);
      expect_word(16'hF083, 8'h83);
      redirect(8'h80);
      chk("r_occ0", occupancy, 0);
      chk("r_read", rom_read, 1);
      chk("r_addr", rom_addr, 8'h80);
      drain("r_drain");

      // wrap-around
      rom[1] = 16'hF001;
      expect_word(16'h10FE, 8'hFE);
      expect_word(16'h10FF, 8'hFF);
      expect_word(16'h1000, 8'h00);
      expect_word(16'hF001, 8'h01);
      redirect(8'hFE);
      chk("w_addr_fe", rom_addr, 8'hFE);
      step(2);
      chk("w_addr_00", rom_addr, 8'h00);
      drain("w_drain");

      // reset mid-stream
      issue_if.ready = 1'b0;
      redirect(8'h10);
      step(3);
      chk("m_occ2", occupancy, 2);
      resetn = 1'b0;
      #1;
      chk("m_occ", occupancy, 0);
      chk("m_valid", issue_if.valid, 0);
      chk("m_read", rom_read, 0);
      step(2);
      issue_if.ready = 1'b1;
      expect_word(16'h1000, 8'h00);
      expect_word(16'hF001, 8'h01);
      resetn = 1'b1;
      #1;
      chk("m_rel_read", rom_read, 1);
      chk("m_rel_addr", rom_addr, 0);
      drain("m_drain");
      step(3);
      chk("m_occ_end", occupancy, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
